// File: rtl/decode_stage_pkg.sv
// Shared control enums, opcode constants and the ID/EX bundle type for the RV64I decode stage.
// Opcode classification helpers are used by the decoder and the hazard logic.
package decode_stage_pkg;

    localparam int unsigned PC_W = 64;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_REG    = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_IMMW   = 7'b0011011;
    localparam logic [6:0] OPC_REGW   = 7'b0111011;

    typedef enum logic [2:0] {I_IMM, S_IMM, B_IMM, U_IMM, J_IMM} immgen_op_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
        ALU_OR, ALU_AND, ALU_ADDW, ALU_SUBW, ALU_SLLW, ALU_SRLW, ALU_SRAW
    } alu_op_t;

    typedef enum logic [2:0] {
        CMP_NO, CMP_EQ, CMP_NE, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU
    } cmp_op_t;

    typedef enum logic [1:0] {ASEL_REG, ASEL_PC, ASEL_ZERO} alu_asel_t;
    typedef enum logic {BSEL_IMM, BSEL_REG} alu_bsel_t;
    typedef enum logic [1:0] {WB_SEL0, WB_ALU, WB_MEM, WB_PC4} wb_sel_t;

    typedef enum logic [2:0] {
        MEM_NO, MEM_B, MEM_H, MEM_W, MEM_D, MEM_BU, MEM_HU, MEM_WU
    } mem_op_t;

    typedef enum logic [1:0] {NPC_PC4, NPC_BR, NPC_JAL, NPC_JALR} npc_sel_t;

    typedef struct packed {
        logic       we_reg;
        logic       we_mem;
        logic       re_mem;
        npc_sel_t   npc_sel;
        immgen_op_t immgen_op;
        alu_op_t    alu_op;
        cmp_op_t    cmp_op;
        alu_asel_t  alu_asel;
        alu_bsel_t  alu_bsel;
        wb_sel_t    wb_sel;
        mem_op_t    mem_op;
        logic       illegal;
    } ctrl_t;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            we_reg;
        logic            we_mem;
        logic            re_mem;
        npc_sel_t        npc_sel;
        immgen_op_t      immgen_op;
        alu_op_t         alu_op;
        cmp_op_t         cmp_op;
        alu_asel_t       alu_asel;
        alu_bsel_t       alu_bsel;
        wb_sel_t         wb_sel;
        mem_op_t         mem_op;
        logic            illegal;
    } id_ex_t;

    function automatic logic op_uses_rs1(input logic [6:0] opcode);
        return !(opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
    endfunction

    function automatic logic op_uses_rs2(input logic [6:0] opcode);
        return opcode inside {OPC_STORE, OPC_REG, OPC_REGW, OPC_BRANCH};
    endfunction

    // SUB only exists in the register form; SRAI/SRA share funct7[5] with SRLI/SRL.
    function automatic alu_op_t alu_arith(input logic [2:0] funct3, input logic alt,
                                          input logic is_reg);
        alu_op_t op;
        case (funct3)
            3'd0:    op = (alt & is_reg) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    function automatic alu_op_t alu_word(input logic [2:0] funct3, input logic alt,
                                         input logic is_reg);
        alu_op_t op;
        case (funct3)
            3'd0:    op = (alt & is_reg) ? ALU_SUBW : ALU_ADDW;
            3'd1:    op = ALU_SLLW;
            3'd5:    op = alt ? ALU_SRAW : ALU_SRLW;
            default: op = ALU_ADDW;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/inst_decoder.sv
// Combinational RV64I instruction decoder: opcode/funct fields to control fields, illegal flag
// and register-use classification.
module inst_decoder
    import decode_stage_pkg::*;
#(
    parameter bit RV64_EN = 1'b1
) (
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output ctrl_t      ctrl,
    output logic       use_rs1,
    output logic       use_rs2
);

    assign use_rs1 = op_uses_rs1(opcode);
    assign use_rs2 = op_uses_rs2(opcode);

    always_comb begin
        ctrl = '0;
        case (opcode)
            OPC_LOAD: begin
                ctrl.we_reg = 1'b1;
                ctrl.re_mem = 1'b1;
                ctrl.wb_sel = WB_MEM;
                case (funct3)
                    3'd0: ctrl.mem_op = MEM_B;
                    3'd1: ctrl.mem_op = MEM_H;
                    3'd2: ctrl.mem_op = MEM_W;
                    3'd3: begin
                        ctrl.mem_op  = MEM_D;
                        ctrl.illegal = ~RV64_EN;
                    end
                    3'd4: ctrl.mem_op = MEM_BU;
                    3'd5: ctrl.mem_op = MEM_HU;
                    3'd6: begin
                        ctrl.mem_op  = MEM_WU;
                        ctrl.illegal = ~RV64_EN;
                    end
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OPC_STORE: begin
                ctrl.we_mem    = 1'b1;
                ctrl.immgen_op = S_IMM;
                case (funct3)
                    3'd0: ctrl.mem_op = MEM_B;
                    3'd1: ctrl.mem_op = MEM_H;
                    3'd2: ctrl.mem_op = MEM_W;
                    3'd3: begin
                        ctrl.mem_op  = MEM_D;
                        ctrl.illegal = ~RV64_EN;
                    end
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OPC_IMM: begin
                ctrl.we_reg = 1'b1;
                ctrl.wb_sel = WB_ALU;
                ctrl.alu_op = alu_arith(funct3, funct7_5, 1'b0);
            end
            OPC_REG: begin
                ctrl.we_reg   = 1'b1;
                ctrl.wb_sel   = WB_ALU;
                ctrl.alu_bsel = BSEL_REG;
                ctrl.alu_op   = alu_arith(funct3, funct7_5, 1'b1);
            end
            OPC_BRANCH: begin
                // ALU forms the target; the comparator decides the direction.
                ctrl.immgen_op = B_IMM;
                ctrl.alu_asel  = ASEL_PC;
                ctrl.npc_sel   = NPC_BR;
                case (funct3)
                    3'd0:    ctrl.cmp_op = CMP_EQ;
                    3'd1:    ctrl.cmp_op = CMP_NE;
                    3'd4:    ctrl.cmp_op = CMP_LT;
                    3'd5:    ctrl.cmp_op = CMP_GE;
                    3'd6:    ctrl.cmp_op = CMP_LTU;
                    3'd7:    ctrl.cmp_op = CMP_GEU;
                    default: ctrl.illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                ctrl.we_reg    = 1'b1;
                ctrl.immgen_op = J_IMM;
                ctrl.alu_asel  = ASEL_PC;
                ctrl.wb_sel    = WB_PC4;
                ctrl.npc_sel   = NPC_JAL;
            end
            OPC_JALR: begin
                ctrl.we_reg  = 1'b1;
                ctrl.wb_sel  = WB_PC4;
                ctrl.npc_sel = NPC_JALR;
            end
            OPC_LUI: begin
                ctrl.we_reg    = 1'b1;
                ctrl.immgen_op = U_IMM;
                ctrl.alu_asel  = ASEL_ZERO;
                ctrl.wb_sel    = WB_ALU;
            end
            OPC_AUIPC: begin
                ctrl.we_reg    = 1'b1;
                ctrl.immgen_op = U_IMM;
                ctrl.alu_asel  = ASEL_PC;
                ctrl.wb_sel    = WB_ALU;
            end
            OPC_IMMW: begin
                ctrl.we_reg  = 1'b1;
                ctrl.wb_sel  = WB_ALU;
                ctrl.alu_op  = alu_word(funct3, funct7_5, 1'b0);
                ctrl.illegal = ~RV64_EN;
            end
            OPC_REGW: begin
                ctrl.we_reg   = 1'b1;
                ctrl.wb_sel   = WB_ALU;
                ctrl.alu_bsel = BSEL_REG;
                ctrl.alu_op   = alu_word(funct3, funct7_5, 1'b1);
                ctrl.illegal  = ~RV64_EN;
            end
            default: ctrl.illegal = 1'b1;
        endcase

        // An illegal instruction must not change architectural or memory state.
        if (ctrl.illegal) begin
            ctrl.we_reg  = 1'b0;
            ctrl.we_mem  = 1'b0;
            ctrl.re_mem  = 1'b0;
            ctrl.mem_op  = MEM_NO;
            ctrl.wb_sel  = WB_SEL0;
            ctrl.npc_sel = NPC_PC4;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered ID/EX decode stage with valid/ready handshake, load-use bubble insertion,
// synchronous flush and a saturating stall counter.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int unsigned XLEN    = 64,
    parameter bit          RV64_EN = 1'b1,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_inst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             ex_valid,
    input  logic             ex_ready,
    output id_ex_t           ex_bundle,
    output logic [CNT_W-1:0] stall_cnt
);

    ctrl_t            dec_ctrl;
    logic             use_rs1;
    logic             use_rs2;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic             hz;
    logic             accept;
    id_ex_t           bundle_d, bundle_q;
    logic             valid_d, valid_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    inst_decoder #(
        .RV64_EN(RV64_EN)
    ) u_inst_decoder (
        .opcode  (if_inst[6:0]),
        .funct3  (if_inst[14:12]),
        .funct7_5(if_inst[30]),
        .ctrl    (dec_ctrl),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2)
    );

    assign rs1 = if_inst[19:15];
    assign rs2 = if_inst[24:20];

    always_comb begin
        bundle_d           = '0;
        bundle_d.pc        = PC_W'(if_pc);
        bundle_d.inst      = if_inst;
        bundle_d.rs1       = rs1;
        bundle_d.rs2       = rs2;
        bundle_d.rd        = if_inst[11:7];
        bundle_d.we_reg    = dec_ctrl.we_reg;
        bundle_d.we_mem    = dec_ctrl.we_mem;
        bundle_d.re_mem    = dec_ctrl.re_mem;
        bundle_d.npc_sel   = dec_ctrl.npc_sel;
        bundle_d.immgen_op = dec_ctrl.immgen_op;
        bundle_d.alu_op    = dec_ctrl.alu_op;
        bundle_d.cmp_op    = dec_ctrl.cmp_op;
        bundle_d.alu_asel  = dec_ctrl.alu_asel;
        bundle_d.alu_bsel  = dec_ctrl.alu_bsel;
        bundle_d.wb_sel    = dec_ctrl.wb_sel;
        bundle_d.mem_op    = dec_ctrl.mem_op;
        bundle_d.illegal   = dec_ctrl.illegal;
    end

    // Load data is not forwardable from EX, so a dependent consumer waits one cycle.
    assign hz = valid_q & bundle_q.re_mem & (bundle_q.rd != 5'd0) & if_valid &
                ((use_rs1 & (rs1 == bundle_q.rd)) | (use_rs2 & (rs2 == bundle_q.rd)));

    assign if_ready = rstn & ~flush & ~hz & (~valid_q | ex_ready);
    assign accept   = if_valid & if_ready;

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (accept) begin
            valid_d = 1'b1;
        end else if (valid_q & ex_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hz & ex_ready & ~flush & ~(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q  <= 1'b0;
            bundle_q <= '0;
            cnt_q    <= '0;
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                bundle_q <= bundle_d;
            end
        end
    end

    assign ex_valid  = valid_q;
    assign ex_bundle = bundle_q;
    assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (RV64 on with 32-bit counter, RV64 off with 2-bit
// counter) driven in lockstep and compared every cycle against a behavioural model.
module tb_decode_stage;
    import decode_stage_pkg::*;

    localparam logic [31:0] I_ADDI   = 32'h0050_0093; // addi x1,x0,5
    localparam logic [31:0] I_ADD    = 32'h0011_01B3; // add  x3,x2,x1
    localparam logic [31:0] I_LW     = 32'h0000_A103; // lw   x2,0(x1)
    localparam logic [31:0] I_LW0    = 32'h0000_2003; // lw   x0,0(x0)
    localparam logic [31:0] I_ADD0   = 32'h0000_01B3; // add  x3,x0,x0
    localparam logic [31:0] I_ADDW   = 32'h0010_80BB; // addw x1,x1,x1
    localparam logic [31:0] I_BADOPC = 32'h0000_007F;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        flush = 1'b0;
    logic        if_valid = 1'b0;
    logic        ex_ready = 1'b0;
    logic [31:0] if_inst = '0;
    logic [63:0] if_pc = '0;

    logic        if_ready_a, ex_valid_a, if_ready_b, ex_valid_b;
    id_ex_t      bundle_a, bundle_b;
    logic [31:0] cnt_a;
    logic [1:0]  cnt_b;

    int n_checks = 0;
    int n_pass   = 0;

    bit              m_valid[2];
    id_ex_t          m_b[2];
    longint unsigned m_cnt[2];

    always #5 clk = ~clk;

    decode_stage #(.XLEN(64), .RV64_EN(1'b1), .CNT_W(32)) u_dut_a (
        .clk(clk), .rstn(rstn), .flush(flush), .if_valid(if_valid), .if_ready(if_ready_a),
        .if_inst(if_inst), .if_pc(if_pc), .ex_valid(ex_valid_a), .ex_ready(ex_ready),
        .ex_bundle(bundle_a), .stall_cnt(cnt_a)
    );

    decode_stage #(.XLEN(64), .RV64_EN(1'b0), .CNT_W(2)) u_dut_b (
        .clk(clk), .rstn(rstn), .flush(flush), .if_valid(if_valid), .if_ready(if_ready_b),
        .if_inst(if_inst), .if_pc(if_pc), .ex_valid(ex_valid_b), .ex_ready(ex_ready),
        .ex_bundle(bundle_b), .stall_cnt(cnt_b)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Expected bundle straight from the ISA decode rules.
    function automatic id_ex_t ref_bundle(input logic [31:0] inst, input logic [63:0] pc,
                                          input bit rv64);
        id_ex_t     b;
        logic [6:0] opc;
        logic [2:0] f3;
        bit         alt, bad;
        alu_op_t    arith[8];
        mem_op_t    ld_w[8];
        mem_op_t    st_w[8];
        cmp_op_t    br_c[8];
        arith = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        ld_w  = '{MEM_B, MEM_H, MEM_W, MEM_D, MEM_BU, MEM_HU, MEM_WU, MEM_NO};
        st_w  = '{MEM_B, MEM_H, MEM_W, MEM_D, MEM_NO, MEM_NO, MEM_NO, MEM_NO};
        br_c  = '{CMP_EQ, CMP_NE, CMP_NO, CMP_NO, CMP_LT, CMP_GE, CMP_LTU, CMP_GEU};
        opc = inst[6:0];
        f3  = inst[14:12];
        alt = inst[30];
        b = '0;
        b.pc   = pc;
        b.inst = inst;
        b.rs1  = inst[19:15];
        b.rs2  = inst[24:20];
        b.rd   = inst[11:7];
        bad = 1'b0;
        case (opc)
            OPC_LOAD: begin
                b.we_reg = 1; b.re_mem = 1; b.wb_sel = WB_MEM; b.mem_op = ld_w[f3];
                bad = (ld_w[f3] == MEM_NO) || (!rv64 && (ld_w[f3] inside {MEM_D, MEM_WU}));
            end
            OPC_STORE: begin
                b.we_mem = 1; b.immgen_op = S_IMM; b.mem_op = st_w[f3];
                bad = (st_w[f3] == MEM_NO) || (!rv64 && st_w[f3] == MEM_D);
            end
            OPC_IMM: begin
                b.we_reg = 1; b.wb_sel = WB_ALU;
                b.alu_op = (f3 == 3'd5 && alt) ? ALU_SRA : arith[f3];
            end
            OPC_REG: begin
                b.we_reg = 1; b.wb_sel = WB_ALU; b.alu_bsel = BSEL_REG;
                b.alu_op = (f3 == 3'd0 && alt) ? ALU_SUB :
                           (f3 == 3'd5 && alt) ? ALU_SRA : arith[f3];
            end
            OPC_BRANCH: begin
                b.immgen_op = B_IMM; b.alu_asel = ASEL_PC; b.npc_sel = NPC_BR;
                b.cmp_op = br_c[f3];
                bad = (br_c[f3] == CMP_NO);
            end
            OPC_JAL: begin
                b.we_reg = 1; b.immgen_op = J_IMM; b.alu_asel = ASEL_PC;
                b.wb_sel = WB_PC4; b.npc_sel = NPC_JAL;
            end
            OPC_JALR: begin
                b.we_reg = 1; b.wb_sel = WB_PC4; b.npc_sel = NPC_JALR;
            end
            OPC_LUI: begin
                b.we_reg = 1; b.immgen_op = U_IMM; b.alu_asel = ASEL_ZERO; b.wb_sel = WB_ALU;
            end
            OPC_AUIPC: begin
                b.we_reg = 1; b.immgen_op = U_IMM; b.alu_asel = ASEL_PC; b.wb_sel = WB_ALU;
            end
            OPC_IMMW, OPC_REGW: begin
                b.we_reg = 1; b.wb_sel = WB_ALU;
                if (opc == OPC_REGW) b.alu_bsel = BSEL_REG;
                if (f3 == 3'd1) b.alu_op = ALU_SLLW;
                else if (f3 == 3'd5) b.alu_op = alt ? ALU_SRAW : ALU_SRLW;
                else if (f3 == 3'd0 && alt && opc == OPC_REGW) b.alu_op = ALU_SUBW;
                else b.alu_op = ALU_ADDW;
                bad = !rv64;
            end
            default: bad = 1'b1;
        endcase
        if (bad) begin
            b.illegal = 1; b.we_reg = 0; b.we_mem = 0; b.re_mem = 0;
            b.mem_op = MEM_NO; b.wb_sel = WB_SEL0; b.npc_sel = NPC_PC4;
        end
        return b;
    endfunction

    function automatic bit is_load(input id_ex_t b);
        return b.inst[6:0] == OPC_LOAD && !b.illegal;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] opcs[11];
        logic [6:0] opc;
        int         sel;
        opcs = '{OPC_LOAD, OPC_STORE, OPC_IMM, OPC_REG, OPC_BRANCH, OPC_JAL, OPC_JALR,
                 OPC_LUI, OPC_AUIPC, OPC_IMMW, OPC_REGW};
        sel = $urandom_range(0, 11);
        opc = (sel == 11) ? 7'($urandom) : opcs[sel];
        return {1'b0, 1'($urandom), 5'($urandom), 5'($urandom_range(0, 3)),
                5'($urandom_range(0, 3)), 3'($urandom), 5'($urandom_range(0, 3)), opc};
    endfunction

    // Check both DUTs against the model mid-cycle, then advance the model across the edge.
    task automatic cycle();
        bit              hz, rdy, u1, u2;
        bit              n_valid[2];
        id_ex_t          n_b[2];
        longint unsigned n_cnt[2];
        longint unsigned cmax;
        logic [4:0]      rs1, rs2;
        string           nm;
        @(negedge clk);
        rs1 = if_inst[19:15];
        rs2 = if_inst[24:20];
        u1  = !(if_inst[6:0] inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        u2  = if_inst[6:0] inside {OPC_STORE, OPC_REG, OPC_REGW, OPC_BRANCH};
        for (int k = 0; k < 2; k++) begin
            nm   = (k == 0) ? "rv64" : "rv32";
            cmax = (k == 0) ? 64'hFFFF_FFFF : 64'd3;
            hz = m_valid[k] && is_load(m_b[k]) && m_b[k].rd != 5'd0 && if_valid &&
                 ((u1 && rs1 == m_b[k].rd) || (u2 && rs2 == m_b[k].rd));
            rdy = !flush && !hz && (!m_valid[k] || ex_ready);
            check({nm, " if_ready"}, 256'((k == 0) ? if_ready_a : if_ready_b), 256'(rdy));
            check({nm, " ex_valid"}, 256'((k == 0) ? ex_valid_a : ex_valid_b),
                  256'(m_valid[k]));
            check({nm, " bundle"}, 256'((k == 0) ? bundle_a : bundle_b), 256'(m_b[k]));
            check({nm, " stall_cnt"}, (k == 0) ? 256'(cnt_a) : 256'(cnt_b), 256'(m_cnt[k]));
            n_valid[k] = m_valid[k];
            n_b[k]     = m_b[k];
            n_cnt[k]   = m_cnt[k];
            if (flush) n_valid[k] = 0;
            else if (if_valid && rdy) begin
                n_valid[k] = 1;
                n_b[k]     = ref_bundle(if_inst, if_pc, k == 0);
            end else if (m_valid[k] && ex_ready) n_valid[k] = 0;
            if (hz && ex_ready && !flush && m_cnt[k] != cmax) n_cnt[k]++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = n_valid[k];
            m_b[k]     = n_b[k];
            m_cnt[k]   = n_cnt[k];
        end
    endtask

    task automatic drive(input bit v, input logic [31:0] inst, input bit rdy, input bit fl);
        if_valid = v;
        if_inst  = inst;
        if_pc    = {$urandom, $urandom};
        ex_ready = rdy;
        flush    = fl;
        cycle();
    endtask

    task automatic reset_now();
        rstn = 1'b0;
        #1;
        check("rst ex_valid", 256'(ex_valid_a), 256'(0));
        check("rst stall_cnt", 256'(cnt_a), 256'(0));
        check("rst if_ready", 256'(if_ready_a), 256'(0));
        check("rst bundle", 256'(bundle_a), 256'(0));
        check("rst bundle rv32", 256'(bundle_b), 256'(0));
        check("rst stall_cnt rv32", 256'(cnt_b), 256'(0));
        for (int k = 0; k < 2; k++) begin
            m_valid[k] = 0;
            m_b[k]     = '0;
            m_cnt[k]   = 0;
        end
    endtask

    initial begin
        id_ex_t saved;
        #1;
        reset_now();
        @(posedge clk);
        #1;
        rstn = 1'b1;

        // Back-to-back independent instructions.
        drive(1, I_ADDI, 1, 0);
        check("addi ex_valid", 256'(ex_valid_a), 256'(1));
        check("addi alu_op", 256'(bundle_a.alu_op), 256'(ALU_ADD));
        check("addi bsel", 256'(bundle_a.alu_bsel), 256'(BSEL_IMM));
        drive(1, I_ADD, 1, 0);
        check("add ex_valid", 256'(ex_valid_a), 256'(1));
        check("add bsel", 256'(bundle_a.alu_bsel), 256'(BSEL_REG));
        check("add stall_cnt", 256'(cnt_a), 256'(0));

        // Load-use: one bubble, then the consumer.
        drive(1, I_LW, 1, 0);
        if_valid = 1; if_inst = I_ADD; ex_ready = 1;
        #1;
        check("hazard if_ready", 256'(if_ready_a), 256'(0));
        cycle();
        check("bubble ex_valid", 256'(ex_valid_a), 256'(0));
        check("bubble stall_cnt", 256'(cnt_a), 256'(1));
        drive(1, I_ADD, 1, 0);
        check("late add ex_valid", 256'(ex_valid_a), 256'(1));
        check("late add inst", 256'(bundle_a.inst), 256'(I_ADD));

        // A load to x0 never stalls.
        drive(1, I_LW0, 1, 0);
        drive(1, I_ADD0, 1, 0);
        check("x0 no bubble", 256'(bundle_a.inst), 256'(I_ADD0));
        check("x0 stall_cnt", 256'(cnt_a), 256'(1));

        // Backpressure hold, then flush.
        drive(1, I_ADDI, 1, 0);
        saved = bundle_a;
        for (int i = 0; i < 3; i++) begin
            drive(1, I_ADD, 0, 0);
            check("hold bundle", 256'(bundle_a), 256'(saved));
            check("hold if_ready", 256'(if_ready_a), 256'(0));
        end
        if_valid = 1; if_inst = I_ADD; ex_ready = 0; flush = 1;
        #1;
        check("flush if_ready", 256'(if_ready_a), 256'(0));
        cycle();
        check("flush ex_valid", 256'(ex_valid_a), 256'(0));
        check("flush drops input", 256'(bundle_a), 256'(saved));

        // RV64 encodings against the RV64-disabled instance, and an unknown opcode.
        drive(1, I_ADDW, 1, 0);
        check("addw illegal rv32", 256'(bundle_b.illegal), 256'(1));
        check("addw we_reg rv32", 256'(bundle_b.we_reg), 256'(0));
        check("addw legal rv64", 256'(bundle_a.illegal), 256'(0));
        drive(1, I_BADOPC, 1, 0);
        check("0x7f illegal", 256'(bundle_a.illegal), 256'(1));
        check("0x7f mem_op", 256'(bundle_a.mem_op), 256'(MEM_NO));

        // Repeated hazards drive the 2-bit counter into saturation.
        for (int i = 0; i < 4; i++) begin
            drive(1, I_LW, 1, 0);
            drive(1, I_ADD, 1, 0);
            drive(1, I_ADD, 1, 0);
        end
        check("sat stall_cnt rv32", 256'(cnt_b), 256'(3));
        check("stall_cnt rv64", 256'(cnt_a), 256'(5));

        // Asynchronous reset while a hazard is pending.
        drive(1, I_LW, 1, 0);
        if_valid = 1; if_inst = I_ADD; ex_ready = 1; flush = 0;
        #1;
        check("pre-reset hazard", 256'(if_ready_a), 256'(0));
        #1;
        reset_now();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        drive(1, I_ADDI, 1, 0);
        check("post-reset accept", 256'(ex_valid_a), 256'(1));
        check("post-reset inst", 256'(bundle_a.inst), 256'(I_ADDI));

        // Randomised traffic with backpressure and occasional flushes.
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 4) != 0, rand_inst(), ($urandom % 4) != 0, ($urandom % 20) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
